// File: rtl/fpu_ss_offload_buffer.sv
// Offload buffer between the accelerator interface and the FPU subsystem decoder.
// Define FPU_SS_OFFLOAD_BUFFER_FALLTHROUGH_EN for fall-through (zero-latency bypass) mode.
package fpu_ss_pkg;

    typedef struct packed {
        logic [31:0]       addr;
        logic [2:0][31:0]  rs;
        logic [31:0]       instr_data;
        logic [31:0]       hart_id;
    } offloaded_data_t;

endpackage

module fpu_ss_offload_buffer
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  offloaded_data_t in_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output offloaded_data_t out_data_o,
    output logic [CNT_W-1:0] usage_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    offloaded_data_t  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] usage;
    logic             push;
    logic             pop;

    assign full_o     = (usage == CNT_W'(DEPTH));
    assign empty_o    = (usage == '0);
    assign usage_o    = usage;
    // Ready depends only on stored occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready_o = !full_o;

`ifdef FPU_SS_OFFLOAD_BUFFER_FALLTHROUGH_EN
    logic bypass;

    assign out_valid_o = !rst_i && !flush_i && (!empty_o || in_valid_i);
    assign out_data_o  = empty_o ? in_data_i : mem[rd_ptr];
    // An entry presented to an empty buffer and consumed at once never touches storage.
    assign bypass      = empty_o && in_valid_i && out_ready_i;
    assign push        = in_valid_i && in_ready_o && !bypass;
`else
    assign out_valid_o = !empty_o;
    assign out_data_o  = mem[rd_ptr];
    assign push        = in_valid_i && in_ready_o;
`endif

    assign pop = out_valid_o && out_ready_i && !empty_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   usage <= usage + CNT_W'(1);
                2'b01:   usage <= usage - CNT_W'(1);
                default: usage <= usage;
            endcase
        end
    end

    // NOTE: payload storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !flush_i) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_fpu_ss_offload_buffer.sv
// Scoreboard bench for fpu_ss_offload_buffer: driver enqueues expected entries,
// negedge monitor pops and compares whenever the DUT hands over its head entry.
module tb_fpu_ss_offload_buffer;
    import fpu_ss_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef FPU_SS_OFFLOAD_BUFFER_FALLTHROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    offloaded_data_t  in_data_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    offloaded_data_t  out_data_o;
    logic [CNT_W-1:0] usage_o;
    logic             full_o;
    logic             empty_o;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    offloaded_data_t exp_q[$];

    fpu_ss_offload_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .usage_o     (usage_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic offloaded_data_t make_data(input int id);
        offloaded_data_t d;
        d.addr       = 32'h1000_0000 + 32'(id * 4);
        d.rs[0]      = 32'(id * 3 + 1);
        d.rs[1]      = ~32'(id);
        d.rs[2]      = {16'(id), 16'hbeef};
        d.instr_data = 32'h0000_0053 | (32'(id) << 7);
        d.hart_id    = 32'(id);
        return d;
    endfunction

    // One clock cycle of stimulus; status outputs are checked against the bench's occupancy model.
    task automatic step(input bit v, input offloaded_data_t d, input bit r, input bit f, input bit rs);
        bit exp_ov;
        bit exp_push;
        bit exp_pop;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        rst_i       = rs;
        #1;
        exp_ov = FT ? (!rs && !f && (model_cnt != 0 || v)) : (model_cnt != 0);
        check("usage",     256'(usage_o),     256'(model_cnt));
        check("in_ready",  256'(in_ready_o),  256'(model_cnt < DEPTH));
        check("full",      256'(full_o),      256'(model_cnt == DEPTH));
        check("empty",     256'(empty_o),     256'(model_cnt == 0));
        check("out_valid", 256'(out_valid_o), 256'(exp_ov));
        exp_push = v && (model_cnt < DEPTH);
        exp_pop  = exp_ov && r;
        if (!rs && !f && exp_push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        if (rs || f) begin
            model_cnt = 0;
            exp_q.delete();
        end else begin
            model_cnt = model_cnt + int'(exp_push) - int'(exp_pop);
        end
    endtask

    task automatic idle(input bit r);
        step(1'b0, '0, r, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && model_cnt != 0; i++) idle(1'b1);
        idle(1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 256'(out_valid_o), 256'(1'b0));
            end else begin
                check("data", 256'(out_data_o), 256'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        offloaded_data_t d;
        int id = 100;

        rst_i = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // Fill to full with hart_id 0..3, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, make_data(i), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Full with simultaneous push and pop: push refused, retried next cycle.
        for (int i = 10; i < 14; i++) step(1'b1, make_data(i), 1'b0, 1'b0, 1'b0);
        d = make_data(14);
        step(1'b1, d, 1'b1, 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        drain();

        // Steady push+pop at occupancy 2 for 10 cycles, pointers wrap.
        step(1'b1, make_data(20), 1'b0, 1'b0, 1'b0);
        step(1'b1, make_data(21), 1'b0, 1'b0, 1'b0);
        for (int i = 22; i < 32; i++) step(1'b1, make_data(i), 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        drain();

        // Flush at occupancy 3 with a push and pop in the same cycle.
        for (int i = 40; i < 43; i++) step(1'b1, make_data(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, make_data(43), 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Single push into empty buffer, then a push with consumer ready.
        d = make_data(50);
        d.instr_data = 32'h0000_0053;
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        step(1'b1, make_data(51), 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Reset mid-stream during a push, then random traffic.
        step(1'b1, make_data(60), 1'b0, 1'b0, 1'b0);
        step(1'b1, make_data(61), 1'b0, 1'b0, 1'b0);
        step(1'b1, make_data(62), 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), make_data(id), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            id++;
        end
        drain();

        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_ss_offload_buffer.md
FPU_SS_OFFLOAD_BUFFER -- requirements
Module: fpu_ss_offload_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, width of occupancy count.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-005 SHALL have port flush_i  input  1  discard all buffered entries.
REQ-006 SHALL have port in_valid_i  input  1  offloaded instruction valid from accelerator interface.
REQ-007 SHALL have port in_ready_o  output  1  buffer accepts in_data_i this cycle.
REQ-008 SHALL have port in_data_i  input  fpu_ss_pkg::offloaded_data_t  addr, rs[2:0], instr_data, hart_id.
REQ-009 SHALL have port out_valid_o  output  1  head entry valid towards FPU subsystem decoder.
REQ-010 SHALL have port out_ready_i  input  1  decoder consumes head entry.
REQ-011 SHALL have port out_data_o  output  fpu_ss_pkg::offloaded_data_t  head entry.
REQ-012 SHALL have port usage_o  output  CNT_W  current occupancy, 0..DEPTH.
REQ-013 SHALL have port full_o / empty_o  output  1 each  occupancy==DEPTH / occupancy==0.

Function
REQ-014 SHALL implement FIFO order: entries leave in exactly the order accepted, payload bit-identical.
REQ-015 Push SHALL occur when in_valid_i && in_ready_o; pop when out_valid_o && out_ready_i.
REQ-016 in_ready_o SHALL equal !full_o, independent of out_ready_i (no combinational ready path in->out).
REQ-017 out_valid_o SHALL equal !empty_o (registered mode); out_data_o SHALL be the head entry, don't-care when empty.
REQ-018 Write/read pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 without a gap.
REQ-019 Simultaneous push and pop SHALL leave usage_o unchanged and advance both pointers.
REQ-020 When full, push SHALL be blocked even if a pop occurs in the same cycle; the freed slot is offered next cycle.
REQ-021 When empty, a pushed entry SHALL appear on out_valid_o/out_data_o the following cycle (1-cycle latency).
REQ-022 usage_o SHALL increment on push-only, decrement on pop-only, never exceed DEPTH nor drop below 0.
REQ-023 flush_i SHALL, at next edge, set both pointers and usage_o to 0; flush has priority over same-cycle push and pop (both discarded).
REQ-024 Payload storage SHALL be written only on push; storage contents need no reset.

Reset
REQ-025 On rst_i high at a clock edge: pointers=0, usage_o=0, empty_o=1, full_o=0, out_valid_o=0, in_ready_o=1.
REQ-026 Reset SHALL take priority over flush_i, push and pop; a push in the reset cycle is lost.
REQ-027 Reset asserted mid-stream SHALL discard all entries; no stale entry SHALL be presented after release.

Configuration
REQ-028 Macro FPU_SS_OFFLOAD_BUFFER_FALLTHROUGH_EN SHALL select fall-through mode when defined.
REQ-029 With macro defined: when empty and in_valid_i=1, out_valid_o=1 and out_data_o=in_data_i combinationally; if out_ready_i=1 the entry bypasses storage and usage_o stays 0; flush_i=1 or rst_i=1 forces out_valid_o=0.
REQ-030 Without macro: behaviour per REQ-017/REQ-021, no combinational in->out path.

Verification
REQ-031 Reset then push 4 entries (hart_id 0..3), out_ready_i=0 -> full_o=1, in_ready_o=0, usage_o=4; then out_ready_i=1 -> hart_id 0,1,2,3 out in order.
REQ-032 Full buffer, in_valid_i=1 and out_ready_i=1 same cycle -> entry popped, new entry not accepted, usage_o=3, accepted next cycle (usage_o=4).
REQ-033 usage_o=2, push and pop same cycle for 10 cycles -> usage_o stays 2, pointers wrap, 10 entries out in order with no corruption.
REQ-034 usage_o=3 with flush_i=1, in_valid_i=1, out_ready_i=1 -> next cycle usage_o=0, empty_o=1, out_valid_o=0; flushed and in-flight entries never appear.
REQ-035 Empty buffer, push instr_data=32'h0000_0053 -> without macro out_valid_o=1 one cycle later; with macro same cycle and, with out_ready_i=1, usage_o remains 0.
REQ-036 rst_i asserted at usage_o=2 during push -> next cycle usage_o=0, out_valid_o=0, in_ready_o=1; random push/pop traffic after release matches a reference queue model.
